// File: rtl/bubble_sort_param.sv
// Handshake-driven bubble sorter: one compare/conditional swap per clock, ascending or descending.
// Optional early exit on a swap-free pass when BUBBLE_SORT_PARAM_EARLY_EXIT_EN is defined.
module bubble_sort_param #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH = 10,
  localparam int unsigned CMP_MAX = DEPTH * (DEPTH - 1) / 2,
  localparam int unsigned CNT_W = $clog2(CMP_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    desc_i,
  input  logic [DEPTH*DATA_W-1:0] data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DEPTH*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]        swap_cnt_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [DATA_W-1:0]       arr_q [DEPTH];
  logic [DATA_W-1:0]       arr_d [DEPTH];
  logic [DEPTH*DATA_W-1:0] arr_flat_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic [IDX_W-1:0]        pass_q, pass_d;
  logic [CNT_W-1:0]        swaps_q, swaps_d;
  logic                    mode_q, mode_d;
  logic                    busy_d, done_d, load_out_d;
  logic [DATA_W-1:0]       cur_c, nxt_c;
  logic                    do_swap_c, pass_end_c, finish_c;
  logic [IDX_W-1:0]        k_inc_c, last_k_c;
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
  logic                    pass_sw_q, pass_sw_d;
`endif

  // Compare the current adjacent pair under the captured ordering
  always_comb begin
    k_inc_c    = k_q + IDX_W'(1);
    cur_c      = arr_q[k_q];
    nxt_c      = arr_q[k_inc_c];
    do_swap_c  = mode_q ? (cur_c < nxt_c) : (cur_c > nxt_c);
    last_k_c   = IDX_W'(DEPTH - 2) - pass_q;
    pass_end_c = (k_q == last_k_c);
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
    finish_c   = pass_end_c && ((pass_q == IDX_W'(DEPTH - 2)) || !(pass_sw_q || do_swap_c));
`else
    finish_c   = pass_end_c && (pass_q == IDX_W'(DEPTH - 2));
`endif
  end

  // Next-state, datapath and output decisions
  always_comb begin
    state_d    = state_q;
    arr_d      = arr_q;
    k_d        = k_q;
    pass_d     = pass_q;
    swaps_d    = swaps_q;
    mode_d     = mode_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    load_out_d = 1'b0;
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
    pass_sw_d  = pass_sw_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          for (int i = 0; i < int'(DEPTH); i++) arr_d[i] = data_i[i*DATA_W +: DATA_W];
          mode_d  = desc_i;
          k_d     = '0;
          pass_d  = '0;
          swaps_d = '0;
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
          pass_sw_d = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = ST_SORT;
        end
      end
      ST_SORT: begin
        busy_d = 1'b1;
        if (do_swap_c) begin
          arr_d[k_q]     = nxt_c;
          arr_d[k_inc_c] = cur_c;
          swaps_d        = swaps_q + CNT_W'(1);
        end
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
        pass_sw_d = pass_sw_q | do_swap_c;
`endif
        if (pass_end_c) begin
          k_d    = '0;
          pass_d = pass_q + IDX_W'(1);
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
          pass_sw_d = 1'b0;
`endif
          if (finish_c) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            load_out_d = 1'b1;
          end
        end else begin
          k_d = k_inc_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arr_flat_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) arr_flat_d[i*DATA_W +: DATA_W] = arr_d[i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Working array, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) arr_q[i] <= '0;
      k_q        <= '0;
      pass_q     <= '0;
      swaps_q    <= '0;
      mode_q     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      data_o     <= '0;
      swap_cnt_o <= '0;
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
      pass_sw_q  <= 1'b0;
`endif
    end else begin
      arr_q   <= arr_d;
      k_q     <= k_d;
      pass_q  <= pass_d;
      swaps_q <= swaps_d;
      mode_q  <= mode_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      if (load_out_d) begin
        data_o     <= arr_flat_d;
        swap_cnt_o <= swaps_d;
      end
`ifdef BUBBLE_SORT_PARAM_EARLY_EXIT_EN
      pass_sw_q <= pass_sw_d;
`endif
    end
  end

endmodule
